// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared tube register addresses and DMA state encoding
package tube_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_NMI,
    TUBE_RD,
    MEM_WR,
    MEM_RD,
    TUBE_WR,
    GAP
  } dma_state_t;

  localparam logic [2:0] REG3_DATA   = 3'h5;
  localparam logic [2:0] REG3_STATUS = 3'h4;

endpackage

// File: rtl/tube_r3_dma.sv
// rtl/tube_r3_dma.sv - PNMI-paced byte mover between tube register 3 and parasite memory
module tube_r3_dma
  import tube_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              p_phi2,
  input  logic              p_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_dir,
  input  logic              cfg_two_byte,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic              p_nmi_b,
  output logic              p_cs_b,
  output logic [2:0]        p_addr,
  output logic              p_rdnw,
  input  logic [7:0]        p_data_in,
  output logic [7:0]        p_data_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] remaining
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  dma_state_t        state, state_d, after_byte;
  logic              dir_q, two_q, second_q;
  logic [7:0]        byte_q, gap_q;
  logic [ADDR_W-1:0] addr_q, rem_q, rem_dec;
  logic              load, step, capture, done_d, aborted_d;

  assign rem_dec   = rem_q - ADDR_W'(1);
  assign mem_addr  = addr_q;
  assign remaining = rem_q;
  assign mem_wdata = byte_q;
  assign busy      = (state != IDLE);

  // A second byte in two-byte mode follows straight on, skipping the PNMI check.
  always_comb begin
    if (two_q && !second_q && rem_dec != '0)
      after_byte = dir_q ? MEM_RD : TUBE_RD;
    else if (GAP_CYCLES > 0)
      after_byte = GAP;
    else if (rem_dec == '0)
      after_byte = IDLE;
    else
      after_byte = WAIT_NMI;
  end

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    load       = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    p_cs_b     = 1'b1;
    p_rdnw     = 1'b1;
    p_addr     = 3'h0;
    p_data_out = 8'h00;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          load = 1'b1;
          if (cfg_count == '0) done_d  = 1'b1;
          else                 state_d = WAIT_NMI;
        end
      end
      WAIT_NMI: begin
        if (!p_nmi_b) state_d = dir_q ? MEM_RD : TUBE_RD;
      end
      TUBE_RD: begin
        p_cs_b  = 1'b0;
        p_addr  = REG3_DATA;
        capture = 1'b1;
        state_d = MEM_WR;
      end
      MEM_WR: begin
        mem_we  = 1'b1;
        step    = 1'b1;
        state_d = after_byte;
        done_d  = (after_byte == IDLE);
      end
      MEM_RD: begin
        mem_re  = 1'b1;
        state_d = TUBE_WR;
      end
      TUBE_WR: begin
        p_cs_b     = 1'b0;
        p_addr     = REG3_DATA;
        p_rdnw     = 1'b0;
        p_data_out = mem_rdata;
        step       = 1'b1;
        state_d    = after_byte;
        done_d     = (after_byte == IDLE);
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_NMI;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort cancels the byte in flight, so its address/count update never lands.
    if (abort && state != IDLE) begin
      state_d   = IDLE;
      step      = 1'b0;
      capture   = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) begin
      dir_q    <= 1'b0;
      two_q    <= 1'b0;
      second_q <= 1'b0;
      byte_q   <= 8'h00;
      gap_q    <= 8'h00;
      addr_q   <= '0;
      rem_q    <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done    <= done_d;
      aborted <= aborted_d;
      gap_q   <= (state == GAP) ? gap_q + 8'd1 : 8'd0;
      if (load) begin
        dir_q    <= cfg_dir;
        two_q    <= cfg_two_byte;
        addr_q   <= cfg_base;
        rem_q    <= cfg_count;
        second_q <= 1'b0;
      end
      if (capture) byte_q <= p_data_in;
      if (step) begin
        addr_q   <= addr_q + ADDR_W'(1);
        rem_q    <= rem_dec;
        second_q <= (state_d == TUBE_RD) || (state_d == MEM_RD);
      end
    end
  end

endmodule

// File: tb/tb_tube_r3_dma.sv
// tb/tb_tube_r3_dma.sv - self-checking bench for tube_r3_dma with memory/tube models
module tb_tube_r3_dma;

  logic        p_phi2 = 1'b0, p_rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic        cfg_dir = 1'b0, cfg_two_byte = 1'b0, p_nmi_b = 1'b1;
  logic [15:0] cfg_base = 16'h0, cfg_count = 16'h0;
  logic        p_cs_b, p_rdnw, mem_we, mem_re, busy, done, aborted;
  logic [2:0]  p_addr;
  logic [7:0]  p_data_in, p_data_out, mem_wdata, mem_rdata;
  logic [15:0] mem_addr, remaining;

  int n_cmp = 0, n_bad = 0;

  logic [7:0] rom [0:65535];
  logic [7:0] mem [0:65535];
  logic [7:0] tube_src [0:63];
  logic [7:0] wr_data [0:63];
  int         rd_cyc [0:63];
  int         wr_cyc [0:63];
  logic [7:0] rdq = 8'h00;
  logic       clr = 1'b0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, we_cnt = 0, done_cnt = 0, abort_cnt = 0, bad_addr = 0;

  assign mem_rdata = rdq;
  assign p_data_in = tube_src[rd_cnt & 63];

  tube_r3_dma #(.ADDR_W(16), .GAP_CYCLES(2)) dut (
    .p_phi2(p_phi2), .p_rst(p_rst), .start(start), .abort(abort),
    .cfg_dir(cfg_dir), .cfg_two_byte(cfg_two_byte), .cfg_base(cfg_base), .cfg_count(cfg_count),
    .p_nmi_b(p_nmi_b), .p_cs_b(p_cs_b), .p_addr(p_addr), .p_rdnw(p_rdnw),
    .p_data_in(p_data_in), .p_data_out(p_data_out), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .aborted(aborted), .remaining(remaining)
  );

  always #5 p_phi2 = ~p_phi2;

  // Synchronous-read memory, tube register 3 source/sink and event log.
  always @(posedge p_phi2) begin
    cyc <= cyc + 1;
    if (mem_re) rdq <= rom[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (clr) begin
      rd_cnt <= 0; wr_cnt <= 0; we_cnt <= 0; done_cnt <= 0; abort_cnt <= 0; bad_addr <= 0;
    end else begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (!p_cs_b) begin
        if (p_addr !== 3'h5) bad_addr <= bad_addr + 1;
        if (p_rdnw) begin
          rd_cyc[rd_cnt & 63] <= cyc;
          rd_cnt <= rd_cnt + 1;
        end else begin
          wr_cyc[wr_cnt & 63]  <= cyc;
          wr_data[wr_cnt & 63] <= p_data_out;
          wr_cnt <= wr_cnt + 1;
        end
      end
      if (done)    done_cnt  <= done_cnt + 1;
      if (aborted) abort_cnt <= abort_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge p_phi2);
    #1;
  endtask

  task automatic run_transfer(input logic dir, input logic two, input logic [15:0] base,
                              input int count, input bit junk,
                              output int svc, output int t_nmi, output bit tmo);
    cfg_dir = dir; cfg_two_byte = two; cfg_base = base; cfg_count = 16'(count);
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    if (junk) begin
      cfg_count = 16'h0009; cfg_dir = ~dir; cfg_base = ~base;
      tick(); start = 1'b1; tick(); start = 1'b0;
    end
    tick();
    svc = 0; t_nmi = 0;
    while (busy && svc < count + 2) begin
      p_nmi_b = 1'b0;
      if (svc == 0) t_nmi = cyc;
      tick();
      p_nmi_b = 1'b1;
      svc++;
      repeat ($urandom_range(13, 9)) tick();
    end
    tmo = busy;
  endtask

  task automatic test_reset();
    #1 p_rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, aborted, mem_we, mem_re, p_cs_b, p_rdnw, p_addr} !== 10'b00000_11_000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 0000011000",
               {busy, done, aborted, mem_we, mem_re, p_cs_b, p_rdnw, p_addr});
    end
    n_cmp++;
    if ({mem_addr, remaining, p_data_out, mem_wdata} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h required 0", {mem_addr, remaining, p_data_out, mem_wdata});
    end
    tick(); p_rst = 1'b0; tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_dir0_basic();
    int svc, tn; bit tmo;
    tube_src[0] = 8'hA1; tube_src[1] = 8'hB2; tube_src[2] = 8'hC3;
    run_transfer(1'b0, 1'b0, 16'h1000, 3, 1'b0, svc, tn, tmo);
    n_cmp++;
    if (tmo || svc != 3) begin
      n_bad++; $display("FAIL d0_services: got %0d (timeout %0d) required 3", svc, tmo);
    end
    n_cmp++;
    if ({mem[16'h1000], mem[16'h1001], mem[16'h1002]} !== 24'hA1B2C3) begin
      n_bad++;
      $display("FAIL d0_mem: got %h%h%h required a1b2c3", mem[16'h1000], mem[16'h1001], mem[16'h1002]);
    end
    n_cmp++;
    if (done_cnt != 1 || remaining !== 16'h0) begin
      n_bad++; $display("FAIL d0_done: done_cnt=%0d remaining=%0d required 1 0", done_cnt, remaining);
    end
    n_cmp++;
    if (rd_cyc[0] != tn + 1) begin
      n_bad++; $display("FAIL d0_latency: first read cycle %0d required %0d", rd_cyc[0], tn + 1);
    end
    n_cmp++;
    if (bad_addr != 0 || rd_cnt != 3 || wr_cnt != 0) begin
      n_bad++;
      $display("FAIL d0_bus: bad_addr=%0d rd=%0d wr=%0d required 0 3 0", bad_addr, rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_dir1_two_byte();
    int svc, tn; bit tmo;
    rom[16'h2000] = 8'h11; rom[16'h2001] = 8'h22; rom[16'h2002] = 8'h33; rom[16'h2003] = 8'h44;
    run_transfer(1'b1, 1'b1, 16'h2000, 4, 1'b0, svc, tn, tmo);
    n_cmp++;
    if (tmo || svc != 2) begin
      n_bad++; $display("FAIL d1_services: got %0d (timeout %0d) required 2", svc, tmo);
    end
    n_cmp++;
    if (wr_cnt != 4 || {wr_data[0], wr_data[1], wr_data[2], wr_data[3]} !== 32'h11223344) begin
      n_bad++;
      $display("FAIL d1_data: count %0d data %h%h%h%h required 4 11223344",
               wr_cnt, wr_data[0], wr_data[1], wr_data[2], wr_data[3]);
    end
    n_cmp++;
    if (wr_cyc[1] != wr_cyc[0] + 2 || wr_cyc[3] != wr_cyc[2] + 2 || wr_cyc[2] <= wr_cyc[1] + 2) begin
      n_bad++;
      $display("FAIL d1_spacing: write cycles %0d %0d %0d %0d required pairs 2 apart",
               wr_cyc[0], wr_cyc[1], wr_cyc[2], wr_cyc[3]);
    end
    n_cmp++;
    if (done_cnt != 1 || bad_addr != 0) begin
      n_bad++; $display("FAIL d1_done: done_cnt=%0d bad_addr=%0d required 1 0", done_cnt, bad_addr);
    end
  endtask

  task automatic test_two_byte_odd();
    int svc, tn; bit tmo;
    tube_src[0] = 8'h5A; tube_src[1] = 8'hC7; tube_src[2] = 8'h3E;
    run_transfer(1'b0, 1'b1, 16'h3000, 3, 1'b0, svc, tn, tmo);
    n_cmp++;
    if (tmo || svc != 2 || rd_cnt != 3) begin
      n_bad++; $display("FAIL odd_services: svc=%0d reads=%0d required 2 3", svc, rd_cnt);
    end
    n_cmp++;
    if ({mem[16'h3000], mem[16'h3001], mem[16'h3002]} !== 24'h5AC73E || done_cnt != 1) begin
      n_bad++;
      $display("FAIL odd_mem: got %h%h%h done=%0d required 5ac73e 1",
               mem[16'h3000], mem[16'h3001], mem[16'h3002], done_cnt);
    end
    n_cmp++;
    if (rd_cyc[1] != rd_cyc[0] + 2) begin
      n_bad++; $display("FAIL odd_spacing: read cycles %0d %0d required 2 apart", rd_cyc[0], rd_cyc[1]);
    end
  endtask

  task automatic test_wrap();
    int svc, tn; bit tmo;
    tube_src[0] = 8'h77; tube_src[1] = 8'h88;
    run_transfer(1'b0, 1'b0, 16'hFFFF, 2, 1'b0, svc, tn, tmo);
    n_cmp++;
    if (tmo || mem[16'hFFFF] !== 8'h77 || mem[16'h0000] !== 8'h88 || mem_addr !== 16'h0001) begin
      n_bad++;
      $display("FAIL wrap: ffff=%h 0000=%h addr=%h required 77 88 0001",
               mem[16'hFFFF], mem[16'h0000], mem_addr);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) tube_src[i] = 8'(8'h40 + i);
    cfg_dir = 1'b0; cfg_two_byte = 1'b0; cfg_base = 16'h4000; cfg_count = 16'd5;
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    p_nmi_b = 1'b0; tick(); p_nmi_b = 1'b1;
    repeat (10) tick();
    p_nmi_b = 1'b0; tick(); p_nmi_b = 1'b1;
    tick();
    n_cmp++;
    if (mem_we !== 1'b1 || remaining !== 16'd4) begin
      n_bad++; $display("FAIL abort_setup: mem_we=%b remaining=%0d required 1 4", mem_we, remaining);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if ({aborted, done, busy, p_cs_b, mem_we, mem_re} !== 6'b100100 || remaining !== 16'd4) begin
      n_bad++;
      $display("FAIL abort_state: aborted/done/busy/cs_b/we/re=%b remaining=%0d required 100100 4",
               {aborted, done, busy, p_cs_b, mem_we, mem_re}, remaining);
    end
    repeat (4) tick();
    n_cmp++;
    if (done_cnt != 0 || abort_cnt != 1) begin
      n_bad++; $display("FAIL abort_pulses: done=%0d aborted=%0d required 0 1", done_cnt, abort_cnt);
    end
  endtask

  task automatic test_zero_count();
    clr = 1'b1; tick(); clr = 1'b0;
    cfg_count = 16'd0; cfg_dir = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_done: done=%b busy=%b required 1 0", done, busy);
    end
    repeat (4) tick();
    n_cmp++;
    if (done_cnt != 1 || rd_cnt + wr_cnt != 0 || we_cnt != 0) begin
      n_bad++;
      $display("FAIL zero_quiet: done=%0d bus=%0d we=%0d required 1 0 0", done_cnt, rd_cnt + wr_cnt, we_cnt);
    end
  endtask

  task automatic test_start_abort_idle();
    clr = 1'b1; tick(); clr = 1'b0;
    cfg_count = 16'd3; cfg_base = 16'h5000;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 0 || remaining === 16'd3) begin
      n_bad++;
      $display("FAIL start_abort: busy=%b done=%0d remaining=%0d required 0 0 not-3",
               busy, done_cnt, remaining);
    end
  endtask

  task automatic test_reset_mid();
    clr = 1'b1; tick(); clr = 1'b0;
    rom[16'h6000] = 8'h9C;
    cfg_dir = 1'b1; cfg_two_byte = 1'b1; cfg_base = 16'h6000; cfg_count = 16'd6;
    start = 1'b1; tick(); start = 1'b0; tick();
    p_nmi_b = 1'b0; tick(); p_nmi_b = 1'b1;
    tick();
    n_cmp++;
    if (p_cs_b !== 1'b0 || p_data_out !== 8'h9C) begin
      n_bad++; $display("FAIL rstmid_setup: cs_b=%b data=%h required 0 9c", p_cs_b, p_data_out);
    end
    #2 p_rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, aborted, mem_we, mem_re, p_cs_b, p_rdnw, p_addr} !== 10'b00000_11_000 ||
        {mem_addr, remaining, p_data_out, mem_wdata} !== 48'h0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: ctrl=%b data=%h required 0000011000 0",
               {busy, done, aborted, mem_we, mem_re, p_cs_b, p_rdnw, p_addr},
               {mem_addr, remaining, p_data_out, mem_wdata});
    end
    tick(); p_rst = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (done_cnt != 0 || abort_cnt != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_pulses: done=%0d aborted=%0d busy=%b required 0 0 0", done_cnt, abort_cnt, busy);
    end
  endtask

  task automatic test_random();
    logic        dir, two;
    logic [15:0] base;
    logic [7:0]  exp_b [0:7];
    logic [7:0]  got;
    int          cnt, svc, tn, errs, exp_svc;
    bit          tmo;
    for (int t = 0; t < 16; t++) begin
      dir  = 1'($urandom);
      two  = 1'($urandom);
      cnt  = $urandom_range(8, 1);
      base = ($urandom_range(3, 0) == 0) ? 16'hFFFF - 16'($urandom_range(4, 0)) : 16'($urandom);
      for (int i = 0; i < cnt; i++) begin
        exp_b[i] = 8'($urandom);
        if (dir) rom[16'(base + 16'(i))] = exp_b[i];
        else     tube_src[i] = exp_b[i];
      end
      run_transfer(dir, two, base, cnt, 1'($urandom), svc, tn, tmo);
      exp_svc = two ? (cnt + 1) / 2 : cnt;
      n_cmp++;
      if (tmo || svc != exp_svc || done_cnt != 1) begin
        n_bad++;
        $display("FAIL rnd%0d_services: svc=%0d done=%0d timeout=%0d required %0d 1 0",
                 t, svc, done_cnt, tmo, exp_svc);
      end
      errs = 0;
      for (int i = 0; i < cnt; i++) begin
        got = dir ? wr_data[i] : mem[16'(base + 16'(i))];
        if (got !== exp_b[i]) errs++;
      end
      n_cmp++;
      if (errs != 0 || (dir ? wr_cnt : rd_cnt) != cnt || bad_addr != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_data: byte errors=%0d bus=%0d bad_addr=%0d required 0 %0d 0",
                 t, errs, dir ? wr_cnt : rd_cnt, bad_addr, cnt);
      end
      n_cmp++;
      if (remaining !== 16'h0 || mem_addr !== 16'(base + 16'(cnt))) begin
        n_bad++;
        $display("FAIL rnd%0d_final: remaining=%0d addr=%h required 0 %h",
                 t, remaining, mem_addr, 16'(base + 16'(cnt)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_dir0_basic();
    test_dir1_two_byte();
    test_two_byte_odd();
    test_wrap();
    test_abort();
    test_zero_count();
    test_start_abort_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tube_r3_dma.md
TUBE_R3_DMA -- requirements
Module: tube_r3_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address and byte-count width.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles after each NMI service before PNMI is re-sampled.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-004 p_phi2  input  1  parasite clock; all state updates on its rising edge.
REQ-005 p_rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that launches a transfer.
REQ-007 abort  input  1  cancels the active transfer.
REQ-008 cfg_dir  input  1  transfer direction: 0 = host->parasite (read reg 3, write memory); 1 = parasite->host.
REQ-009 cfg_two_byte  input  1  two bytes serviced per PNMI (mirrors tube flag V).
REQ-010 cfg_base  input  ADDR_W  start memory address.
REQ-011 cfg_count  input  ADDR_W  byte count.
REQ-012 p_nmi_b  input  1  tube PNMI, active low, synchronous to p_phi2.
REQ-013 p_cs_b, p_addr[2:0], p_rdnw  output  tube parasite bus control.
REQ-014 p_data_in  input  8  read data from tube.
REQ-015 p_data_out  output  8  write data to tube.
REQ-016 mem_addr  output  ADDR_W  memory address.
REQ-017 mem_we, mem_re  output  1  memory write and read strobes.
REQ-018 mem_wdata  output  8  memory write data.
REQ-019 mem_rdata  input  8  memory read data, valid one cycle after mem_re.
REQ-020 busy, done, aborted  output  1  status; done and aborted are one-cycle pulses.
REQ-021 remaining  output  ADDR_W  bytes not yet transferred.

Function
REQ-022 States SHALL be IDLE, WAIT_NMI, TUBE_RD, MEM_WR, MEM_RD, TUBE_WR, GAP.
REQ-023 In IDLE, a start pulse SHALL latch cfg_*; remaining SHALL be set to cfg_count, and the block SHALL go to WAIT_NMI with busy=1 on the next cycle.
REQ-024 start with cfg_count=0 SHALL produce done=1 on the next cycle with no bus or memory cycle, and busy SHALL stay 0.
REQ-025 start while busy SHALL be ignored.
REQ-026 In WAIT_NMI, p_nmi_b=0 SHALL move the block to TUBE_RD (cfg_dir=0) or MEM_RD (cfg_dir=1).
REQ-027 TUBE_RD SHALL last 1 cycle with p_cs_b=0, p_addr=3'h5, p_rdnw=1; p_data_in SHALL be captured at its end.
REQ-028 MEM_WR SHALL last 1 cycle with mem_we=1 and mem_wdata equal to the captured byte.
REQ-029 MEM_RD SHALL last 1 cycle with mem_re=1.
REQ-030 TUBE_WR SHALL last 1 cycle with p_cs_b=0, p_addr=3'h5, p_rdnw=0, and p_data_out equal to mem_rdata captured at the start of the cycle.
REQ-031 Per byte, mem_addr SHALL increment by 1 and remaining SHALL decrement by 1 on exit from MEM_WR or TUBE_WR; mem_addr SHALL wrap from all-ones to 0.
REQ-032 When cfg_two_byte=1 and remaining>0 after the first byte, the second byte SHALL follow immediately without re-checking PNMI.
REQ-033 After each service, the block SHALL spend GAP_CYCLES cycles in GAP and then go to WAIT_NMI, or to IDLE with done=1 if remaining=0.
REQ-034 abort SHALL return the block to IDLE on the next edge in any state, with aborted=1 for one cycle, done=0, all strobes deasserted and remaining held.
REQ-035 If start and abort are both asserted in IDLE, abort SHALL win and nothing SHALL launch.
REQ-036 Outside TUBE_RD/TUBE_WR: p_cs_b=1, p_rdnw=1, p_addr=0.
REQ-037 Each byte SHALL take 2 cycles; latency from PNMI low to the first bus cycle SHALL be 1 cycle.

Reset
REQ-038 p_rst SHALL force the following immediately and asynchronously: state IDLE; busy, done, aborted, mem_we, mem_re = 0; p_cs_b=1, p_rdnw=1; p_addr, mem_addr, remaining, p_data_out, mem_wdata = 0.
REQ-039 Reset during a transfer SHALL discard it with no done or aborted pulse.

Structure
REQ-040 The state enumeration and tube register address constants (REG3_DATA=3'h5, REG3_STATUS=3'h4) SHALL be placed in shared package tube_pkg.
REQ-041 The block SHALL be a single flat module with no sub-module.

Verification
REQ-042 dir=0, base=0x1000, count=3, one-byte mode, tube supplies A1,B2,C3 on three PNMI pulses -> memory holds 0x1000..0x1002 = A1,B2,C3, done is pulsed once, remaining=0.
REQ-043 dir=1, two-byte mode, count=4, memory holds 11,22,33,44 -> exactly two PNMI services, each with two back-to-back tube writes to addr 5, in order 11,22,33,44.
REQ-044 two-byte mode, count=3 -> the second service performs one byte only, then done.
REQ-045 base=0xFFFF, count=2 -> bytes land at 0xFFFF then 0x0000.
REQ-046 abort asserted during MEM_WR of byte 2 of 5 -> aborted pulsed, no done, remaining=4, bus idle next cycle.
REQ-047 count=0 start -> done on the next cycle, p_cs_b never low; p_rst asserted mid-transfer -> all outputs at reset values immediately.
